excpt_ctrl: RTL and testbench



---
 rtl/excpt_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_excpt_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/excpt_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : excpt_ctrl
//  Purpose  : Exception/interrupt initiator on the pipeline side of CP0.
//             At a commit boundary it decides whether to take an interrupt,
//             a syscall or an eret. It writes EPC, Cause and Status to CP0
//             one per cycle, keeps the pipeline stalled, and then issues a
//             redirect PC.
//  Revision : 1.0  initial release
// ============================================================================
module excpt_ctrl #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_0040,
    parameter logic [4:0]  CODE_INT   = 5'd0,
    parameter logic [4:0]  CODE_SYS   = 5'd8
) (
    input  logic        clk,
    input  logic        rst,            // active-low, asynchronous
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        commit_syscall,
    input  logic        commit_eret,
    input  logic [5:0]  intimer,
    input  logic [31:0] cp0rData,
    output logic [4:0]  cp0rAddr,
    output logic        cp0we,
    output logic [4:0]  cp0wAddr,
    output logic [31:0] cp0wData,
    output logic        flush,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [4:0] c_ADDR_STATUS = 5'd12;
    localparam logic [4:0] c_ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] c_ADDR_EPC    = 5'd14;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_EPC    = 3'd1,
        S_W_CAUSE  = 3'd2,
        S_W_STATUS = 3'd3,
        S_E_RD     = 3'd4,
        S_E_WS     = 3'd5,
        S_REDIR    = 3'd6
    } state_t;

    state_t      r_state,      w_state_nx;
    logic [31:0] r_epc_cap,    w_epc_cap_nx;
    logic [4:0]  r_code,       w_code_nx;
    logic [5:0]  r_pend,       w_pend_nx;
    logic [31:0] r_status_cap, w_status_cap_nx;
    logic [31:0] r_epc_ret,    w_epc_ret_nx;
    logic        r_is_eret,    w_is_eret_nx;

    logic [31:0] w_status;
    logic        w_int_take;

    logic [4:0]  w_cp0rAddr_nx;
    logic        w_cp0we_nx;
    logic [4:0]  w_cp0wAddr_nx;
    logic [31:0] w_cp0wData_nx;
    logic        w_flush_nx;
    logic        w_stall_nx;
    logic        w_redirect_valid_nx;
    logic [31:0] w_redirect_pc_nx;

    // Decision logic, captures, and next-cycle output values (registered below)
    always_comb begin
        w_state_nx      = r_state;
        w_epc_cap_nx    = r_epc_cap;
        w_code_nx       = r_code;
        w_pend_nx       = r_pend;
        w_status_cap_nx = r_status_cap;
        w_epc_ret_nx    = r_epc_ret;
        w_is_eret_nx    = r_is_eret;

        // In IDLE the read port points at Status, so cp0rData is Status here
        w_status   = cp0rData;
        w_int_take = commit_valid & w_status[0] & ~w_status[1]
                   & (|(intimer & w_status[15:10]));

        case (r_state)
            S_IDLE: begin
                if (w_int_take) begin
                    // EPC points past the interrupted instruction; a
                    // simultaneous syscall is dropped
                    w_epc_cap_nx    = commit_pc + 32'd4;
                    w_code_nx       = CODE_INT;
                    w_pend_nx       = intimer;
                    w_status_cap_nx = w_status;
                    w_is_eret_nx    = 1'b0;
                    w_state_nx      = S_W_EPC;
                end else if (commit_valid && commit_syscall) begin
                    w_epc_cap_nx    = commit_pc;
                    w_code_nx       = CODE_SYS;
                    w_pend_nx       = intimer;
                    w_status_cap_nx = w_status;
                    w_is_eret_nx    = 1'b0;
                    w_state_nx      = S_W_EPC;
                end else if (commit_valid && commit_eret) begin
                    w_status_cap_nx = w_status;
                    w_is_eret_nx    = 1'b1;
                    w_state_nx      = S_E_RD;
                end
            end
            S_W_EPC:    w_state_nx = S_W_CAUSE;
            S_W_CAUSE:  w_state_nx = S_W_STATUS;
            S_W_STATUS: w_state_nx = S_REDIR;
            S_E_RD: begin
                // Read port points at EPC during this state
                w_epc_ret_nx = cp0rData;
                w_state_nx   = S_E_WS;
            end
            S_E_WS:     w_state_nx = S_REDIR;
            S_REDIR:    w_state_nx = S_IDLE;
            default:    w_state_nx = S_IDLE;
        endcase

        // Outputs are a function of the state being entered, so they line
        // up with that state once registered
        w_cp0rAddr_nx       = c_ADDR_STATUS;
        w_cp0we_nx          = 1'b0;
        w_cp0wAddr_nx       = 5'd0;
        w_cp0wData_nx       = 32'd0;
        w_flush_nx          = 1'b0;
        w_stall_nx          = (w_state_nx != S_IDLE);
        w_redirect_valid_nx = 1'b0;
        w_redirect_pc_nx    = 32'd0;

        case (w_state_nx)
            S_W_EPC: begin
                w_cp0we_nx    = 1'b1;
                w_cp0wAddr_nx = c_ADDR_EPC;
                w_cp0wData_nx = w_epc_cap_nx;
                w_flush_nx    = 1'b1;
            end
            S_W_CAUSE: begin
                w_cp0we_nx    = 1'b1;
                w_cp0wAddr_nx = c_ADDR_CAUSE;
                w_cp0wData_nx = {16'b0, w_pend_nx, 3'b0, w_code_nx, 2'b0};
            end
            S_W_STATUS: begin
                w_cp0we_nx    = 1'b1;
                w_cp0wAddr_nx = c_ADDR_STATUS;
                w_cp0wData_nx = w_status_cap_nx | 32'h0000_0002;
            end
            S_E_RD: begin
                w_cp0rAddr_nx = c_ADDR_EPC;
                w_flush_nx    = 1'b1;
            end
            S_E_WS: begin
                w_cp0we_nx    = 1'b1;
                w_cp0wAddr_nx = c_ADDR_STATUS;
                w_cp0wData_nx = w_status_cap_nx & ~32'h0000_0002;
            end
            S_REDIR: begin
                w_redirect_valid_nx = 1'b1;
                w_redirect_pc_nx    = w_is_eret_nx ? w_epc_ret_nx : HANDLER_PC;
            end
            default: ;
        endcase
    end

    // State, captured values and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_epc_cap      <= 32'd0;
            r_code         <= 5'd0;
            r_pend         <= 6'd0;
            r_status_cap   <= 32'd0;
            r_epc_ret      <= 32'd0;
            r_is_eret      <= 1'b0;
            cp0rAddr       <= c_ADDR_STATUS;
            cp0we          <= 1'b0;
            cp0wAddr       <= 5'd0;
            cp0wData       <= 32'd0;
            flush          <= 1'b0;
            stall          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            r_state        <= w_state_nx;
            r_epc_cap      <= w_epc_cap_nx;
            r_code         <= w_code_nx;
            r_pend         <= w_pend_nx;
            r_status_cap   <= w_status_cap_nx;
            r_epc_ret      <= w_epc_ret_nx;
            r_is_eret      <= w_is_eret_nx;
            cp0rAddr       <= w_cp0rAddr_nx;
            cp0we          <= w_cp0we_nx;
            cp0wAddr       <= w_cp0wAddr_nx;
            cp0wData       <= w_cp0wData_nx;
            flush          <= w_flush_nx;
            stall          <= w_stall_nx;
            redirect_valid <= w_redirect_valid_nx;
            redirect_pc    <= w_redirect_pc_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_excpt_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_excpt_ctrl
//  Purpose  : Directed bench for excpt_ctrl with a small CP0 register model
//             (Status/Cause/EPC) supplying the combinational read port.
//  Revision : 1.0  initial release
// ============================================================================
module tb_excpt_ctrl;

    logic        clk;
    logic        rst;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_syscall;
    logic        commit_eret;
    logic [5:0]  intimer;
    logic [31:0] cp0rData;
    logic [4:0]  cp0rAddr;
    logic        cp0we;
    logic [4:0]  cp0wAddr;
    logic [31:0] cp0wData;
    logic        flush;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_pass  = 0;
    int n_total = 0;

    excpt_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_syscall (commit_syscall),
        .commit_eret    (commit_eret),
        .intimer        (intimer),
        .cp0rData       (cp0rData),
        .cp0rAddr       (cp0rAddr),
        .cp0we          (cp0we),
        .cp0wAddr       (cp0wAddr),
        .cp0wData       (cp0wData),
        .flush          (flush),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CP0 model: bench presets take priority over DUT writes
    logic [31:0] m_status, m_cause, m_epc;
    logic        set_en;
    logic [4:0]  set_addr;
    logic [31:0] set_data;

    always_comb begin
        case (cp0rAddr)
            5'd12:   cp0rData = m_status;
            5'd13:   cp0rData = m_cause;
            5'd14:   cp0rData = m_epc;
            default: cp0rData = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (set_en) begin
            if (set_addr == 5'd12) m_status <= set_data;
            if (set_addr == 5'd13) m_cause  <= set_data;
            if (set_addr == 5'd14) m_epc    <= set_data;
        end else if (cp0we) begin
            if (cp0wAddr == 5'd12) m_status <= cp0wData;
            if (cp0wAddr == 5'd13) m_cause  <= cp0wData;
            if (cp0wAddr == 5'd14) m_epc    <= cp0wData;
        end
    end

    logic [72:0] obs;
    assign obs = {cp0we, cp0wAddr, cp0wData, flush, stall, redirect_valid, redirect_pc};

    function automatic logic [72:0] pk(input logic we, input logic [4:0] wa,
                                       input logic [31:0] wd, input logic fl,
                                       input logic st, input logic rv,
                                       input logic [31:0] rp);
        return {we, wa, wd, fl, st, rv, rp};
    endfunction

    task automatic idle_inputs();
        commit_valid   = 1'b0;
        commit_pc      = 32'd0;
        commit_syscall = 1'b0;
        commit_eret    = 1'b0;
        intimer        = 6'd0;
    endtask

    // Preset a CP0 register; returns at a negedge after the model has it
    task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        set_en = 1'b1; set_addr = a; set_data = d;
        @(negedge clk);
        set_en = 1'b0;
    endtask

    task automatic drive_commit(input logic [31:0] pc, input logic sys,
                                input logic er, input logic [5:0] irq);
        commit_valid = 1'b1; commit_pc = pc;
        commit_syscall = sys; commit_eret = er; intimer = irq;
    endtask

    task automatic test_reset();
        n_total++;
        if (obs !== 73'd0) $display("FAIL reset_outputs: got %h required %h", obs, 73'd0);
        else n_pass++;
        n_total++;
        if (cp0rAddr !== 5'd12) $display("FAIL reset_rdaddr: got %0d required 12", cp0rAddr);
        else n_pass++;
    endtask

    task automatic test_interrupt();
        logic [72:0] exp [1:5];
        exp[1] = pk(1'b1, 5'd14, 32'h104,  1'b1, 1'b1, 1'b0, 32'h0);
        exp[2] = pk(1'b1, 5'd13, 32'h400,  1'b0, 1'b1, 1'b0, 32'h0);
        exp[3] = pk(1'b1, 5'd12, 32'hFC03, 1'b0, 1'b1, 1'b0, 32'h0);
        exp[4] = pk(1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b1, 32'h40);
        exp[5] = 73'd0;
        set_reg(5'd12, 32'h0000_FC01);
        drive_commit(32'h100, 1'b0, 1'b0, 6'b000001);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) idle_inputs();
            n_total++;
            if (obs !== exp[c]) $display("FAIL interrupt c%0d: got %h required %h", c, obs, exp[c]);
            else n_pass++;
        end
    endtask

    task automatic test_syscall();
        logic [72:0] exp [1:5];
        exp[1] = pk(1'b1, 5'd14, 32'h200, 1'b1, 1'b1, 1'b0, 32'h0);
        exp[2] = pk(1'b1, 5'd13, 32'h20,  1'b0, 1'b1, 1'b0, 32'h0);
        exp[3] = pk(1'b1, 5'd12, 32'h3,   1'b0, 1'b1, 1'b0, 32'h0);
        exp[4] = pk(1'b0, 5'd0,  32'h0,   1'b0, 1'b1, 1'b1, 32'h40);
        exp[5] = 73'd0;
        set_reg(5'd12, 32'h0000_0001);
        drive_commit(32'h200, 1'b1, 1'b0, 6'b000000);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) idle_inputs();
            n_total++;
            if (obs !== exp[c]) $display("FAIL syscall c%0d: got %h required %h", c, obs, exp[c]);
            else n_pass++;
        end
    endtask

    task automatic test_eret();
        logic [72:0] exp [1:4];
        exp[1] = pk(1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b0, 32'h0);
        exp[2] = pk(1'b1, 5'd12, 32'hFC01, 1'b0, 1'b1, 1'b0, 32'h0);
        exp[3] = pk(1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b1, 32'h204);
        exp[4] = 73'd0;
        set_reg(5'd14, 32'h0000_0204);
        set_reg(5'd12, 32'h0000_FC03);
        drive_commit(32'h300, 1'b0, 1'b1, 6'b000000);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                idle_inputs();
                n_total++;
                if (cp0rAddr !== 5'd14) $display("FAIL eret_rdaddr: got %0d required 14", cp0rAddr);
                else n_pass++;
            end
            n_total++;
            if (obs !== exp[c]) $display("FAIL eret c%0d: got %h required %h", c, obs, exp[c]);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        logic [72:0] exp [1:4];
        // IE=0: interrupt masked, syscall taken, pend still recorded
        exp[1] = pk(1'b1, 5'd14, 32'h300,  1'b1, 1'b1, 1'b0, 32'h0);
        exp[2] = pk(1'b1, 5'd13, 32'h420,  1'b0, 1'b1, 1'b0, 32'h0);
        exp[3] = pk(1'b1, 5'd12, 32'hFC02, 1'b0, 1'b1, 1'b0, 32'h0);
        exp[4] = pk(1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b1, 32'h40);
        set_reg(5'd12, 32'h0000_FC00);
        drive_commit(32'h300, 1'b1, 1'b0, 6'b000001);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) idle_inputs();
            n_total++;
            if (obs !== exp[c]) $display("FAIL prio_ie0 c%0d: got %h required %h", c, obs, exp[c]);
            else n_pass++;
        end
        // IE=1: interrupt wins over syscall
        exp[1] = pk(1'b1, 5'd14, 32'h304,  1'b1, 1'b1, 1'b0, 32'h0);
        exp[2] = pk(1'b1, 5'd13, 32'h400,  1'b0, 1'b1, 1'b0, 32'h0);
        exp[3] = pk(1'b1, 5'd12, 32'hFC03, 1'b0, 1'b1, 1'b0, 32'h0);
        set_reg(5'd12, 32'h0000_FC01);
        drive_commit(32'h300, 1'b1, 1'b0, 6'b000001);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) idle_inputs();
            n_total++;
            if (obs !== exp[c]) $display("FAIL prio_ie1 c%0d: got %h required %h", c, obs, exp[c]);
            else n_pass++;
        end
    endtask

    task automatic test_masked();
        // EXL set
        set_reg(5'd12, 32'h0000_FC03);
        drive_commit(32'h100, 1'b0, 1'b0, 6'b000001);
        @(negedge clk); idle_inputs();
        n_total++;
        if (obs !== 73'd0) $display("FAIL masked_exl: got %h required %h", obs, 73'd0);
        else n_pass++;
        // Pending line not enabled in IM
        set_reg(5'd12, 32'h0000_0401);
        drive_commit(32'h100, 1'b0, 1'b0, 6'b000010);
        @(negedge clk); idle_inputs();
        n_total++;
        if (obs !== 73'd0) $display("FAIL masked_im: got %h required %h", obs, 73'd0);
        else n_pass++;
        // No commit, interrupt pending and enabled
        set_reg(5'd12, 32'h0000_FC01);
        intimer = 6'b000001;
        @(negedge clk); idle_inputs();
        n_total++;
        if (obs !== 73'd0) $display("FAIL no_commit: got %h required %h", obs, 73'd0);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        logic [72:0] exp [1:6];
        exp[1] = pk(1'b1, 5'd14, 32'h200, 1'b1, 1'b1, 1'b0, 32'h0);
        exp[2] = pk(1'b1, 5'd13, 32'h20,  1'b0, 1'b1, 1'b0, 32'h0);
        exp[3] = pk(1'b1, 5'd12, 32'h3,   1'b0, 1'b1, 1'b0, 32'h0);
        exp[4] = pk(1'b0, 5'd0,  32'h0,   1'b0, 1'b1, 1'b1, 32'h40);
        exp[5] = 73'd0;
        exp[6] = 73'd0;
        set_reg(5'd12, 32'h0000_0001);
        drive_commit(32'h200, 1'b1, 1'b0, 6'b000000);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1 || c == 3) idle_inputs();
            n_total++;
            if (obs !== exp[c]) $display("FAIL busy_ignore c%0d: got %h required %h", c, obs, exp[c]);
            else n_pass++;
            if (c == 2) drive_commit(32'h500, 1'b1, 1'b0, 6'b000000);
        end
    endtask

    task automatic test_reset_mid();
        set_reg(5'd12, 32'h0000_FC01);
        drive_commit(32'h100, 1'b0, 1'b0, 6'b000001);
        @(negedge clk); idle_inputs();
        @(negedge clk);
        n_total++;
        if (cp0wAddr !== 5'd13) $display("FAIL rst_mid_pre: got addr %0d required 13", cp0wAddr);
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++;
        if ({obs, cp0rAddr} !== {73'd0, 5'd12})
            $display("FAIL rst_mid_async: got %h/%0d required 0/12", obs, cp0rAddr);
        else n_pass++;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (obs !== 73'd0) $display("FAIL rst_mid_after: got %h required %h", obs, 73'd0);
        else n_pass++;
    endtask

    task automatic test_wrap();
        set_reg(5'd12, 32'h0000_FC01);
        drive_commit(32'hFFFF_FFFC, 1'b0, 1'b0, 6'b000001);
        @(negedge clk); idle_inputs();
        n_total++;
        if (obs !== pk(1'b1, 5'd14, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0))
            $display("FAIL epc_wrap: got %h required %h", obs,
                     pk(1'b1, 5'd14, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0));
        else n_pass++;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        set_en = 1'b0; set_addr = 5'd0; set_data = 32'd0;
        idle_inputs();
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_interrupt();
        test_syscall();
        test_eret();
        test_priority();
        test_masked();
        test_busy_ignore();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish required finish within 200000ns");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
